// File: rtl/exe_mem_pkg.sv
// Shared definitions for the EXE-stage memory request unit: size codes, op field positions,
// FSM states and the byte-lane mask helper.
package exe_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Bit positions inside in_mem_op = {is_mem, is_store, size[1:0]}
    localparam int unsigned OP_IS_MEM   = 3;
    localparam int unsigned OP_IS_STORE = 2;
    localparam int unsigned OP_SIZE_HI  = 1;
    localparam int unsigned OP_SIZE_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } exe_state_e;

    typedef struct packed {
        logic       is_mem;
        logic       is_store;
        logic [1:0] size;
    } mem_op_t;

    // Byte-lane mask for an access of size sz at lane offset ofs, aligned down, clipped to all_mask.
    function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] ofs,
                                             input logic [7:0] all_mask);
        logic [7:0] m;
        unique case (sz)
            SZ_B:    m = 8'h01 << ofs;
            SZ_H:    m = 8'h03 << {ofs[2:1], 1'b0};
            SZ_W:    m = 8'h0f << {ofs[2], 2'b00};
            default: m = all_mask;
        endcase
        return m & all_mask;
    endfunction

endpackage

// File: rtl/exe_mem_outst_tracker.sv
// Outstanding-request and flushed-response counters for the data-SRAM channel.
module exe_mem_outst_tracker #(
    parameter int unsigned OUTST_DEPTH = 2,
    parameter int unsigned CNT_W       = $clog2(OUTST_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             discard_inc,
    output logic             full,
    output logic             resp_drop,
    output logic [CNT_W-1:0] outst_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            discard_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

    // The bus answers in order, so any pending discard belongs to the oldest responses.
    always_comb begin
        drop      = dec && (discard_q != '0);
        cnt_d     = cnt_q;
        discard_d = discard_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        unique case ({discard_inc, drop})
            2'b10:   discard_d = discard_q + CNT_W'(1);
            2'b01:   discard_d = discard_q - CNT_W'(1);
            default: discard_d = discard_q;
        endcase
    end

    assign full      = (cnt_q == CNT_W'(OUTST_DEPTH));
    assign resp_drop = drop;
    assign outst_cnt = cnt_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(dec && (cnt_q == '0)));

endmodule

// File: rtl/exe_mem_req_unit.sv
// EXE-stage memory request unit: byte strobes, lane-replicated store data, ALE and a
// flush-safe data-SRAM request channel. Optional EXE_MEM_PERF_EN adds request/stall counters.
module exe_mem_req_unit
    import exe_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OUTST_DEPTH = 2,
    localparam int unsigned LANES      = DATA_W / 8,
    localparam int unsigned OFS_W      = $clog2(LANES),
    localparam int unsigned CNT_W      = $clog2(OUTST_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mem_op,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_ex,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OFS_W+3:0]  out_info,
    output logic              out_ale,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [LANES-1:0]  wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    output logic              resp_drop,
    output logic [CNT_W-1:0]  outst_cnt
`ifdef EXE_MEM_PERF_EN
    ,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [7:0] ALL_LANES = 8'((16'd1 << LANES) - 16'd1);

    exe_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    mem_op_t           op_q, op_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ex_q, ex_d;
    logic              flush_seen_q, flush_seen_d;
    logic              issued_q, issued_d;

    logic              misaligned;
    logic              ale;
    logic              want_mem;
    logic              load;
    logic              handshake;
    logic              done_fire;
    logic              discard_inc;
    logic              full;
    logic [7:0]        mask8;
    logic [DATA_W-1:0] wdata_rep;

`ifdef EXE_MEM_PERF_EN
    logic [31:0] perf_req_q, perf_req_d;
    logic [31:0] perf_stall_q, perf_stall_d;
`endif

    // State register: FSM state, stage payload and optional perf counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            op_q         <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ex_q         <= 1'b0;
            flush_seen_q <= 1'b0;
            issued_q     <= 1'b0;
`ifdef EXE_MEM_PERF_EN
            perf_req_q   <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            op_q         <= op_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ex_q         <= ex_d;
            flush_seen_q <= flush_seen_d;
            issued_q     <= issued_d;
`ifdef EXE_MEM_PERF_EN
            perf_req_q   <= perf_req_d;
            perf_stall_q <= perf_stall_d;
`endif
        end
    end

    always_comb begin
        unique case (op_q.size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_q[0];
            SZ_W:    misaligned = (addr_q[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (addr_q[2:0] != 3'b000);
        endcase
    end

    assign ale         = valid_q && op_q.is_mem && misaligned;
    assign want_mem    = op_q.is_mem && !ex_q && !ale;
    assign in_ready    = !valid_q || ((state_q == ST_DONE) && out_ready);
    assign load        = in_valid && in_ready && !flush;
    assign handshake   = req && addr_ok;
    assign done_fire   = out_valid && out_ready;
    assign discard_inc = handshake && (flush_seen_q || flush);

    // Next-state logic; an op waits in IDLE while the outstanding window is full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_q && !flush) begin
                    if (!want_mem) begin
                        state_d = ST_DONE;
                    end else if (!full) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (addr_ok) begin
                    state_d = (flush_seen_q || flush) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || done_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage payload: capture on handshake, kill on flush, retire on MEM accept.
    always_comb begin
        valid_d      = valid_q;
        op_d         = op_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ex_d         = ex_q;
        flush_seen_d = flush_seen_q;
        issued_d     = issued_q;
        if (load) begin
            valid_d       = 1'b1;
            op_d.is_mem   = in_mem_op[OP_IS_MEM];
            op_d.is_store = in_mem_op[OP_IS_STORE];
            op_d.size     = in_mem_op[OP_SIZE_HI:OP_SIZE_LO];
            signed_d      = in_signed;
            addr_d        = in_addr;
            wdata_d       = in_wdata;
            ex_d          = in_ex;
            flush_seen_d  = 1'b0;
            issued_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (flush) valid_d = 1'b0;
                end
                ST_ISSUE: begin
                    flush_seen_d = flush_seen_q || flush;
                    if (addr_ok) begin
                        if (flush_seen_q || flush) begin
                            valid_d      = 1'b0;
                            flush_seen_d = 1'b0;
                        end else begin
                            issued_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush || done_fire) valid_d = 1'b0;
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        unique case (op_q.size)
            SZ_B:    wdata_rep = {LANES{wdata_q[7:0]}};
            SZ_H:    wdata_rep = {(LANES / 2){wdata_q[15:0]}};
            SZ_W:    wdata_rep = {(DATA_W / 32){wdata_q[31:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    // Output decode; bus fields are held from the stage register for the whole ISSUE window.
    always_comb begin
        mask8     = lane_mask(op_q.size, 3'(addr_q[OFS_W-1:0]), ALL_LANES);
        req       = (state_q == ST_ISSUE);
        wr        = req && op_q.is_store;
        size      = req ? op_q.size : 2'b00;
        addr      = req ? addr_q : '0;
        wdata     = req ? wdata_rep : '0;
        wstrb     = wr ? mask8[LANES-1:0] : '0;
        out_valid = (state_q == ST_DONE) && valid_q && !flush_seen_q;
        out_info  = {addr_q[OFS_W-1:0], op_q.size, signed_q, issued_q};
        out_ale   = ale;
    end

`ifdef EXE_MEM_PERF_EN
    always_comb begin
        perf_req_d   = perf_req_q;
        perf_stall_d = perf_stall_q;
        if (handshake)          perf_req_d   = perf_req_q + 32'd1;
        if (req && !addr_ok)    perf_stall_d = perf_stall_q + 32'd1;
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

    exe_mem_outst_tracker #(
        .OUTST_DEPTH (OUTST_DEPTH),
        .CNT_W       (CNT_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .inc         (handshake),
        .dec         (data_ok),
        .discard_inc (discard_inc),
        .full        (full),
        .resp_drop   (resp_drop),
        .outst_cnt   (outst_cnt)
    );

endmodule

// File: tb/tb_exe_mem_req_unit.sv
// Self-checking bench for exe_mem_req_unit (DATA_W=32, OUTST_DEPTH=2): directed scenarios then random traffic.
module tb_exe_mem_req_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;
    localparam int LANES  = DATA_W / 8;
    localparam int OFS_W  = 2;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mem_op;
    logic              in_signed;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              in_ex;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OFS_W+3:0]  out_info;
    logic              out_ale;
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [LANES-1:0]  wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic              resp_drop;
    logic [CNT_W-1:0]  outst_cnt;
`ifdef EXE_MEM_PERF_EN
    logic [31:0]       perf_req_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    exe_mem_req_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUTST_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op), .in_signed(in_signed),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_ex(in_ex), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info), .out_ale(out_ale),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .resp_drop(resp_drop), .outst_cnt(outst_cnt)
`ifdef EXE_MEM_PERF_EN
        , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one op in the stage, moving waiting -> on-bus -> presenting.
    localparam int PH_WAIT = 0;
    localparam int PH_BUS  = 1;
    localparam int PH_PRES = 2;

    bit          m_v, m_fl, m_iss, m_mem, m_st, m_sg, m_ex, last_cap;
    logic [1:0]  m_sz;
    logic [31:0] m_addr, m_wd;
    int          m_ph, m_cnt, m_disc;

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (nbytes(sz) > LANES) || ((int'(a[2:0]) % nbytes(sz)) != 0);
    endfunction

    function automatic logic [LANES-1:0] strb_of(input logic [1:0] sz, input logic [31:0] a);
        logic [LANES-1:0] s;
        int base;
        base = (int'(a[2:0]) % LANES) / nbytes(sz) * nbytes(sz);
        for (int i = 0; i < LANES; i++) s[i] = (i >= base) && (i < base + nbytes(sz));
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] rep_of(input logic [1:0] sz, input logic [31:0] src);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*8 +: 8] = src[(i % nbytes(sz))*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_v = 0; m_fl = 0; m_iss = 0; m_ph = PH_WAIT; m_cnt = 0; m_disc = 0; last_cap = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_mem_op = '0; in_signed = 0; in_addr = '0; in_wdata = '0; in_ex = 0;
        flush = 0; out_ready = 0; addr_ok = 0; data_ok = 0;
    endtask

    // Called at posedge+1; compares all outputs against the model at the negedge.
    task automatic sample();
        bit e_req, e_ov, e_rdy;
        logic [OFS_W+3:0] e_info;
        #4;
        e_req = m_v && (m_ph == PH_BUS);
        e_ov  = m_v && (m_ph == PH_PRES);
        e_rdy = !m_v || ((m_ph == PH_PRES) && out_ready);
        check_eq("req", 64'(req), 64'(e_req));
        check_eq("in_ready", 64'(in_ready), 64'(e_rdy));
        check_eq("out_valid", 64'(out_valid), 64'(e_ov));
        check_eq("out_ale", 64'(out_ale), 64'(m_v && m_mem && misaligned(m_sz, m_addr)));
        check_eq("resp_drop", 64'(resp_drop), 64'(data_ok && (m_disc > 0)));
        check_eq("outst_cnt", 64'(outst_cnt), 64'(m_cnt));
        check_eq("wstrb", 64'(wstrb), 64'((e_req && m_st) ? strb_of(m_sz, m_addr) : '0));
        if (e_req) begin
            check_eq("addr", 64'(addr), 64'(m_addr));
            check_eq("wr", 64'(wr), 64'(m_st));
            check_eq("size", 64'(size), 64'(m_sz));
            if (m_st) check_eq("wdata", 64'(wdata), 64'(rep_of(m_sz, m_wd)));
        end
        if (e_ov) begin
            e_info = {m_addr[OFS_W-1:0], m_sz, m_sg, m_iss};
            check_eq("out_info", 64'(out_info), 64'(e_info));
        end
    endtask

    // Crosses the next posedge and applies the spec rules to the model; returns at posedge+1.
    task automatic advance();
        bit rdy, cap, hs, fhs, drop;
        int ncnt;
        rdy  = !m_v || ((m_ph == PH_PRES) && out_ready);
        cap  = in_valid && rdy && !flush;
        hs   = m_v && (m_ph == PH_BUS) && addr_ok;
        fhs  = hs && (m_fl || flush);
        drop = data_ok && (m_disc > 0);
        ncnt = m_cnt + int'(hs) - int'(data_ok);
        if (ncnt < 0) ncnt = 0;
        @(posedge clk);
        if (cap) begin
            m_v = 1; m_ph = PH_WAIT; m_fl = 0; m_iss = 0;
            m_mem = in_mem_op[3]; m_st = in_mem_op[2]; m_sz = in_mem_op[1:0];
            m_sg = in_signed; m_addr = in_addr; m_wd = in_wdata; m_ex = in_ex;
        end else if (m_v) begin
            case (m_ph)
                PH_WAIT: begin
                    if (flush) m_v = 0;
                    else if (!m_mem || m_ex || misaligned(m_sz, m_addr)) m_ph = PH_PRES;
                    else if (m_cnt < DEPTH) m_ph = PH_BUS;
                end
                PH_BUS: begin
                    if (flush) m_fl = 1;
                    if (addr_ok) begin
                        if (m_fl) m_v = 0;
                        else begin m_ph = PH_PRES; m_iss = 1; end
                    end
                end
                default: if (flush || out_ready) m_v = 0;
            endcase
        end
        last_cap = cap;
        m_cnt  = ncnt;
        m_disc = m_disc + int'(fhs) - int'(drop);
        #1;
    endtask

    task automatic send_op(input logic mem, input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        in_valid = 1; in_mem_op = {mem, st, sz}; in_signed = sg; in_addr = a; in_wdata = wd; in_ex = 0;
        last_cap = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            advance();
            if (last_cap) break;
        end
        check_eq("send_accepted", 64'(last_cap), 64'd1);
        in_valid = 0;
    endtask

    task automatic run_until_issue();
        for (int i = 0; i < 10; i++) begin
            if (m_v && (m_ph == PH_BUS)) break;
            sample();
            advance();
        end
        check_eq("reached_issue", 64'(m_v && (m_ph == PH_BUS)), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", 64'(req), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_outst_cnt", 64'(outst_cnt), 64'd0);
        check_eq("rst_wstrb", 64'(wstrb), 64'd0);
        check_eq("rst_out_ale", 64'(out_ale), 64'd0);
        reset = 0;

        // st.b 0x1003 <- 0xAB, addr_ok withheld two cycles
        send_op(1, 1, 2'd0, 0, 32'h1003, 32'hAB);
        run_until_issue();
        sample();
        check_eq("stb_req", 64'(req), 64'd1);
        check_eq("stb_wstrb", 64'(wstrb), 64'h8);
        check_eq("stb_wdata", 64'(wdata), 64'hABABABAB);
        advance();
        sample(); check_eq("stb_req_hold", 64'(req), 64'd1); advance();
        addr_ok = 1;
        sample(); check_eq("stb_req_ok", 64'(req), 64'd1); advance();
        addr_ok = 0; out_ready = 1;
        sample();
        check_eq("stb_out_valid", 64'(out_valid), 64'd1);
        check_eq("stb_cnt", 64'(outst_cnt), 64'd1);
        advance();
        data_ok = 1; sample(); advance(); data_ok = 0;

        // ld.w 0x6: ALE, no request, presented next cycle
        send_op(1, 0, 2'd2, 1, 32'h6, 32'h0);
        sample();
        check_eq("ale_flag", 64'(out_ale), 64'd1);
        check_eq("ale_no_req", 64'(req), 64'd0);
        advance();
        sample();
        check_eq("ale_out_valid", 64'(out_valid), 64'd1);
        check_eq("ale_no_req2", 64'(req), 64'd0);
        advance();

        // three loads against a depth-2 window with no responses
        addr_ok = 1; out_ready = 1;
        send_op(1, 0, 2'd2, 0, 32'h100, 0);
        send_op(1, 0, 2'd2, 0, 32'h104, 0);
        send_op(1, 0, 2'd2, 0, 32'h108, 0);
        for (int i = 0; i < 4; i++) begin
            sample(); check_eq("full_hold_req", 64'(req), 64'd0); advance();
        end
        check_eq("full_cnt", 64'(outst_cnt), 64'd2);
        data_ok = 1; sample(); advance(); data_ok = 0;
        sample(); check_eq("after_dok_wait", 64'(req), 64'd0); advance();
        sample(); check_eq("after_dok_issue", 64'(req), 64'd1); advance();
        sample(); advance();
        addr_ok = 0; data_ok = 1;
        sample(); advance(); sample(); advance();
        data_ok = 0;

        // flush while requesting; addr_ok three cycles later
        send_op(1, 0, 2'd2, 0, 32'h200, 0);
        run_until_issue();
        flush = 1; sample(); check_eq("fl_req0", 64'(req), 64'd1); advance(); flush = 0;
        for (int i = 0; i < 2; i++) begin
            sample(); check_eq("fl_req_hold", 64'(req), 64'd1); advance();
        end
        addr_ok = 1; sample(); check_eq("fl_req_ok", 64'(req), 64'd1); advance(); addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            sample(); check_eq("fl_no_out_valid", 64'(out_valid), 64'd0); advance();
        end
        check_eq("fl_cnt", 64'(outst_cnt), 64'd1);
        data_ok = 1; sample(); check_eq("fl_resp_drop", 64'(resp_drop), 64'd1); advance(); data_ok = 0;
        sample(); check_eq("fl_cnt_drained", 64'(outst_cnt), 64'd0); advance();

        // simultaneous addr_ok and data_ok with one outstanding
        addr_ok = 1;
        send_op(1, 0, 2'd1, 0, 32'h300, 0);
        run_until_issue();
        sample(); advance();
        addr_ok = 0;
        send_op(1, 0, 2'd1, 0, 32'h302, 0);
        run_until_issue();
        addr_ok = 1; data_ok = 1;
        sample(); check_eq("sim_cnt_before", 64'(outst_cnt), 64'd1); advance();
        addr_ok = 0; data_ok = 0;
        sample(); check_eq("sim_cnt_after", 64'(outst_cnt), 64'd1); advance();
        data_ok = 1; sample(); advance(); data_ok = 0;

        // asynchronous reset in the middle of a request
        addr_ok = 1;
        send_op(1, 0, 2'd2, 0, 32'h400, 0);
        run_until_issue();
        sample(); advance();
        addr_ok = 0;
        send_op(1, 0, 2'd2, 0, 32'h404, 0);
        run_until_issue();
        check_eq("pre_rst_req", 64'(req), 64'd1);
        check_eq("pre_rst_cnt", 64'(outst_cnt), 64'd1);
        reset = 1;
        #1;
        check_eq("async_rst_req", 64'(req), 64'd0);
        check_eq("async_rst_cnt", 64'(outst_cnt), 64'd0);
        check_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_mem_op = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), sz};
            in_signed = 1'($urandom_range(0, 1));
            in_addr   = a;
            in_wdata  = $urandom;
            in_ex     = 1'($urandom_range(0, 7) == 0);
            flush     = 1'($urandom_range(0, 19) == 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            addr_ok   = 1'($urandom_range(0, 2) != 0);
            data_ok   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
